// File: rtl/logic_cond_loop_engine.sv
// Condition/loop primitive: latches two operands, publishes 1-bit zero/condition flags,
// then counts from val2 up to limit (exclusive). Optional iteration cap: LOOP_TIMEOUT_EN.
module logic_cond_loop_engine #(
   parameter int W1       = 3,
   parameter int W2       = 4,
   parameter int MAX_ITER = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W1-1:0] val1,
   input  logic [W2-1:0] val2,
   input  logic [W2-1:0] limit,
   output logic          busy,
   output logic          flags_valid,
   output logic          val1_zero,
   output logic          val2_zero,
   output logic          both_cond,
   output logic          iter_valid,
   output logic [W2-1:0] iter_val,
   output logic          done,
   output logic          timeout
);

   typedef enum logic [1:0] {IDLE, CHECK, LOOP} state_t;

   state_t        state_q, state_d;
   logic [W1-1:0] v1_q, v1_d;
   logic [W2-1:0] v2_q, v2_d;
   logic [W2-1:0] lim_q, lim_d;
   logic [W2-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          fv_q, fv_d;
   logic          v1z_q, v1z_d;
   logic          v2z_q, v2z_d;
   logic          both_q, both_d;
   logic          itv_q, itv_d;
   logic [W2-1:0] itval_q, itval_d;
   logic          done_q, done_d;
   logic          tmo_q, tmo_d;
   logic          more;
   logic          tmo_hit;

   // cnt_q < lim_q guarantees cnt_q + 1 <= 2^W2-1, so the counter never wraps
   assign more = (cnt_q < lim_q);

`ifdef LOOP_TIMEOUT_EN
   localparam int IW = $clog2(MAX_ITER + 1);
   logic [IW-1:0] itn_q, itn_d;

   // Issuing iteration MAX_ITER+1 is replaced by a timeout exit
   assign tmo_hit = more && (itn_q == IW'(MAX_ITER));

   always_ff @(posedge clk) begin
      if (rst) itn_q <= '0;
      else     itn_q <= itn_d;
   end

   always_comb begin
      itn_d = itn_q;
      if (state_q == IDLE && start)      itn_d = '0;
      else if (state_q == LOOP && more && !tmo_hit) itn_d = itn_q + IW'(1);
   end
`else
   logic cap_unused;
   assign cap_unused = (MAX_ITER != 0);
   assign tmo_hit    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         v1_q    <= '0;
         v2_q    <= '0;
         lim_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         fv_q    <= 1'b0;
         v1z_q   <= 1'b0;
         v2z_q   <= 1'b0;
         both_q  <= 1'b0;
         itv_q   <= 1'b0;
         itval_q <= '0;
         done_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         lim_q   <= lim_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         fv_q    <= fv_d;
         v1z_q   <= v1z_d;
         v2z_q   <= v2z_d;
         both_q  <= both_d;
         itv_q   <= itv_d;
         itval_q <= itval_d;
         done_q  <= done_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      v1_d    = v1_q;
      v2_d    = v2_q;
      lim_d   = lim_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      fv_d    = 1'b0;
      v1z_d   = v1z_q;
      v2z_d   = v2z_q;
      both_d  = both_q;
      itv_d   = 1'b0;
      itval_d = itval_q;
      done_d  = 1'b0;
      tmo_d   = tmo_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               v1_d    = val1;
               v2_d    = val2;
               lim_d   = limit;
               cnt_d   = val2;
               busy_d  = 1'b1;
               tmo_d   = 1'b0;
               state_d = CHECK;
            end
         end
         CHECK: begin
            // Flags are whole-operand logical tests, one bit each
            v1z_d   = (v1_q == '0);
            v2z_d   = (v2_q == '0);
            both_d  = (v1_q != '0) && (v2_q == '0);
            fv_d    = 1'b1;
            state_d = LOOP;
         end
         LOOP: begin
            if (more && !tmo_hit) begin
               itv_d   = 1'b1;
               itval_d = cnt_q;
               cnt_d   = cnt_q + W2'(1);
            end else begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               tmo_d   = tmo_hit;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = busy_q;
   assign flags_valid = fv_q;
   assign val1_zero   = v1z_q;
   assign val2_zero   = v2z_q;
   assign both_cond   = both_q;
   assign iter_valid  = itv_q;
   assign iter_val    = itval_q;
   assign done        = done_q;
   assign timeout     = tmo_q;

endmodule

// File: tb/tb_logic_cond_loop_engine.sv
// Randomized/directed bench for logic_cond_loop_engine against a cycle-offset reference model.
module tb_logic_cond_loop_engine;
   localparam int W1 = 3;
   localparam int W2 = 4;
   localparam int MAX_ITER = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W1-1:0] val1;
   logic [W2-1:0] val2;
   logic [W2-1:0] limit;
   logic          busy, flags_valid, val1_zero, val2_zero, both_cond;
   logic          iter_valid, done, timeout;
   logic [W2-1:0] iter_val;

   int n_chk = 0;
   int n_err = 0;

   logic_cond_loop_engine #(.W1(W1), .W2(W2), .MAX_ITER(MAX_ITER)) dut (
      .clk(clk), .rst(rst), .start(start), .val1(val1), .val2(val2), .limit(limit),
      .busy(busy), .flags_valid(flags_valid), .val1_zero(val1_zero), .val2_zero(val2_zero),
      .both_cond(both_cond), .iter_valid(iter_valid), .iter_val(iter_val), .done(done),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {19'd0, busy, flags_valid, val1_zero, val2_zero, both_cond,
              iter_valid, iter_val, done, timeout};
   endfunction

   // Runs one operation from a negedge; ends at the negedge after the done edge.
   // hold=1 leaves start asserted for the whole operation.
   task automatic run_op(input logic [W1-1:0] v1, input logic [W2-1:0] v2,
                         input logic [W2-1:0] lim, input bit hold);
      int  n;
      bit  to;
      int  last;
      bit  e1z, e2z, ebc;
      n   = (v2 < lim) ? int'(lim) - int'(v2) : 0;
      to  = 1'b0;
`ifdef LOOP_TIMEOUT_EN
      if (n > MAX_ITER) begin
         n  = MAX_ITER;
         to = 1'b1;
      end
`endif
      e1z = (v1 == 0);
      e2z = (v2 == 0);
      ebc = (v1 != 0) && (v2 == 0);
      last = 2 + n;
      val1 = v1; val2 = v2; limit = lim; start = 1'b1;
      for (int k = 0; k <= last; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (!hold) begin
            start = 1'b0;
            val1  = W1'($urandom);
            val2  = W2'($urandom);
            limit = W2'($urandom);
         end
         chk($sformatf("busy k=%0d", k), busy, (k < last));
         chk($sformatf("flags_valid k=%0d", k), flags_valid, (k == 1));
         chk($sformatf("iter_valid k=%0d", k), iter_valid, (k >= 2 && k < last));
         chk($sformatf("done k=%0d", k), done, (k == last));
         chk($sformatf("timeout k=%0d", k), timeout, (k == last) ? to : 1'b0);
         if (k >= 2 && k < last)
            chk($sformatf("iter_val k=%0d", k), iter_val, v2 + k - 2);
         if (k == 1 || k == last)
            chk($sformatf("flags k=%0d", k), {val1_zero, val2_zero, both_cond}, {e1z, e2z, ebc});
      end
   endtask

   initial begin
      logic [W1-1:0] r1;
      logic [W2-1:0] r2, rl;
      rst = 1'b1; start = 1'b0; val1 = '0; val2 = '0; limit = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset outputs", all_outs(), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle outputs", all_outs(), 32'd0);

      run_op(3'b111, 4'd0, 4'd3, 1'b0);
      run_op(3'b000, 4'b0111, 4'd3, 1'b0);
      run_op(3'b010, 4'd12, 4'd15, 1'b0);
      run_op(3'b001, 4'd5, 4'd5, 1'b0);
      run_op(3'b100, 4'd0, 4'd15, 1'b0);
      @(negedge clk);
      chk("timeout holds in idle", timeout, dut.timeout);

      // start held high: second op accepted on the edge after done
      run_op(3'b011, 4'd0, 4'd2, 1'b1);
      run_op(3'b011, 4'd0, 4'd2, 1'b1);
      start = 1'b0;
      @(negedge clk);

      // reset during a 3-iteration loop
      val1 = 3'b101; val2 = 4'd0; limit = 4'd3; start = 1'b1;
      @(posedge clk); @(negedge clk); start = 1'b0;          // E0
      @(posedge clk); @(negedge clk);                         // E1
      @(posedge clk); @(negedge clk);                         // E2
      chk("pre-reset iter", iter_valid, 1'b1);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);                         // E3
      chk("mid-op reset outputs", all_outs(), 32'd0);
      rst = 1'b0;
      repeat (4) begin
         @(posedge clk); @(negedge clk);
         chk("no done after reset", {busy, done, iter_valid}, 3'b000);
      end
      run_op(3'b101, 4'd1, 4'd4, 1'b0);

      for (int i = 0; i < 40; i++) begin
         r1 = W1'($urandom);
         r2 = W2'($urandom);
         rl = W2'($urandom);
         if ($urandom_range(0, 3) == 0) r1 = '0;
         if ($urandom_range(0, 3) == 0) r2 = '0;
         run_op(r1, r2, rl, 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
